// File: rtl/bpred_pkg.sv
// Shared types and constants for the gshare branch predictor front end.
package bpred_pkg;

    // Default predictor index / global history width.
    localparam int unsigned BPRED_W = 10;

    // 2-bit saturating counter states, shared with the counter table.
    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } ctr_state_t;

    localparam ctr_state_t CTR_RESET = CTR_WEAK_NT;

    // One in-flight predicted branch: table index used, direction predicted,
    // and the speculative history checkpoint taken before this branch shifted in.
    typedef struct packed {
        logic [BPRED_W-1:0] index;
        logic               pred;
        logic [BPRED_W-1:0] ghr;
    } bpred_entry_t;

endpackage

// File: rtl/branch_queue.sv
// In-order circular FIFO of in-flight predicted branches with flush.
module branch_queue
    import bpred_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    input  logic         push,
    input  bpred_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output bpred_entry_t head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    bpred_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[head_ptr];

    // Pointer and occupancy tracking; a flush empties the queue and wins over push/pop.
    always_ff @(posedge i_Clk) begin
        if (i_Reset || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push_ok) tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop_ok)  head_ptr <= head_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Entry storage; contents are don't-care after reset or flush.
    always_ff @(posedge i_Clk) begin
        if (push_ok && !flush) begin
            mem[tail_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/gshare_history_queue.sv
// gshare front end: index = PC ^ speculative GHR, in-order branch tracking,
// counter-table update on resolve and GHR repair on mispredict.
module gshare_history_queue
    import bpred_pkg::*;
#(
    parameter int unsigned BPRED_WIDTH = BPRED_W,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_Fetch_Valid,
    input  logic [ADDR_WIDTH-1:0]  i_Fetch_PC,
    input  logic                   i_Is_Branch,
    input  logic                   i_Prediction,
    output logic                   o_Stall,
    input  logic                   i_Resolve_Valid,
    input  logic                   i_Resolve_Outcome,
    output logic [BPRED_WIDTH-1:0] o_Table_Index,
    output logic                   o_Table_Enable,
    output logic                   o_Table_Outcome,
    output logic                   o_Mispredict,
    output logic                   o_Recover_Outcome
);

    logic [BPRED_WIDTH-1:0] ghr_spec;
    logic [BPRED_WIDTH-1:0] predict_index;
    logic [BPRED_WIDTH-1:0] update_index;
    logic                   update_outcome;
    logic                   update_pending;
    logic                   mispredict_q;
    logic                   q_full;
    logic                   q_empty;
    bpred_entry_t           q_head;
    bpred_entry_t           push_entry;
    logic                   fetch_branch;
    logic                   push;
    logic                   resolve_fire;
    logic                   resolve_misp;
    logic                   unused_pc;

    // Only the word-aligned index bits of the PC feed the hash.
    assign unused_pc     = ^{i_Fetch_PC[ADDR_WIDTH-1:BPRED_WIDTH+2], i_Fetch_PC[1:0]};
    assign predict_index = i_Fetch_PC[BPRED_WIDTH+1:2] ^ ghr_spec;

    // The table port is owned by the update during update cycles, so pushes hold off then.
    assign fetch_branch = i_Fetch_Valid & i_Is_Branch;
    assign o_Stall      = fetch_branch & (q_full | update_pending);
    assign push         = fetch_branch & ~o_Stall;
    assign resolve_fire = i_Resolve_Valid & ~q_empty;
    assign resolve_misp = resolve_fire & (q_head.pred != i_Resolve_Outcome);

    assign push_entry = '{index: predict_index, pred: i_Prediction, ghr: ghr_spec};

    branch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (resolve_fire),
        .flush      (resolve_misp),
        .full       (q_full),
        .empty      (q_empty),
        .head       (q_head)
    );

    // Speculative history: repaired from the head checkpoint on mispredict, else shifts on push.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            ghr_spec <= '0;
        end else if (resolve_misp) begin
            ghr_spec <= {q_head.ghr[BPRED_WIDTH-2:0], i_Resolve_Outcome};
        end else if (push) begin
            ghr_spec <= {ghr_spec[BPRED_WIDTH-2:0], i_Prediction};
        end
    end

    // Capture the resolved head for a one-cycle table update and redirect pulse.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            update_pending <= 1'b0;
            mispredict_q   <= 1'b0;
            update_index   <= '0;
            update_outcome <= 1'b0;
        end else begin
            update_pending <= resolve_fire;
            mispredict_q   <= resolve_misp;
            if (resolve_fire) begin
                update_index   <= q_head.index;
                update_outcome <= i_Resolve_Outcome;
            end
        end
    end

    assign o_Table_Index     = update_pending ? update_index : predict_index;
    assign o_Table_Enable    = update_pending;
    assign o_Table_Outcome   = update_outcome;
    assign o_Mispredict      = mispredict_q;
    assign o_Recover_Outcome = update_outcome;

endmodule

// File: doc/gshare_history_queue.md
# gshare_history_queue

Front-end control for the gshare predictor: forms the counter-table index as fetch-PC XOR speculative global history register (GHR), tracks every in-flight predicted branch in an in-order queue, and on in-order resolution drives the counter-table update (enable/index/outcome) and signals mispredictions.

- Sits between fetch and the 2-bit counter table.
- On a mispredict it repairs the GHR from the branch's checkpoint and flushes younger entries.

## Interface
Parameters:
- BPRED_WIDTH, 10, index and GHR width.
- QUEUE_DEPTH, 4, in-flight branch entries; power of two, ≥2.
- ADDR_WIDTH, 32, PC width.

Ports:
- i_Clk  in  1  clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Fetch_Valid  in  1  fetch slot valid.
- i_Fetch_PC  in  ADDR_WIDTH  fetch PC.
- i_Is_Branch  in  1  fetched instruction is a conditional branch.
- i_Prediction  in  1  counter-table prediction for o_Table_Index (same cycle).
- o_Stall  out  1  branch push refused this cycle; fetch holds.
- i_Resolve_Valid  in  1  oldest in-flight branch resolved this cycle.
- i_Resolve_Outcome  in  1  actual direction (1 = taken).
- o_Table_Index  out  BPRED_WIDTH  index to counter table.
- o_Table_Enable  out  1  counter-table update strobe.
- o_Table_Outcome  out  1  outcome written to table.
- o_Mispredict  out  1  one-cycle redirect pulse.
- o_Recover_Outcome  out  1  actual direction of the mispredicted branch; valid with o_Mispredict.

## Operation
- Predict index: PC[BPRED_WIDTH+1:2] ^ GHR_spec.
- Push: a push occurs on an edge where i_Fetch_Valid & i_Is_Branch & !o_Stall.
  - Writes entry {index, i_Prediction, GHR_spec before shift} at the tail.
  - GHR_spec <= {GHR_spec[BPRED_WIDTH-2:0], i_Prediction}.
- Stall: o_Stall = i_Fetch_Valid & i_Is_Branch & (full | update_pending), combinational. Non-branches never stall.
- Resolve: i_Resolve_Valid with queue non-empty pops the head.
  - Latches update_index, update_outcome and mispredict = (head.pred != outcome) into registers.
  - Sets update_pending for exactly the next cycle.
- Update cycle (update_pending = 1):
  - o_Table_Index = update_index, o_Table_Enable = 1, o_Table_Outcome = update_outcome.
  - o_Mispredict = latched mispredict.
  - Otherwise o_Table_Index = predict index and o_Table_Enable = 0.
- Mispredict repair, applied at the resolve edge:
  - GHR_spec <= {head.ghr[BPRED_WIDTH-2:0], outcome}.
  - Count, head and tail are set to 0 (flush). Any same-edge push is discarded.
- Queue pointers wrap modulo QUEUE_DEPTH. Count is $clog2(QUEUE_DEPTH)+1 bits.
- Simultaneous push + correct resolve: both take effect and count is unchanged. Full is evaluated on the pre-edge count (no bypass), so a push to a full queue stalls even if a pop occurs in the same cycle.
- Resolve on an empty queue is ignored: no pop, no update, no mispredict.
- i_Resolve_Valid during the update cycle is legal and pops normally (back-to-back resolves give back-to-back update cycles).

## Timing
- Predict index: combinational from PC and GHR_spec, 0 cycles.
- Resolve → o_Table_Enable/o_Mispredict: 1 cycle; each is a 1-cycle pulse per resolve.
- GHR repair is visible on o_Table_Index path 1 cycle after the resolve edge.
- Reset (any cycle, including mid-update):
  - GHR_spec = 0, queue empty, update_pending = 0.
  - o_Table_Enable = 0, o_Mispredict = 0, o_Table_Outcome = 0, o_Recover_Outcome = 0.
  - o_Stall = 0 unless a branch is fetched during an update (cannot occur in the cycle after reset).
  - Queue contents are don't-care.

## Structure
- Package bpred_pkg holds:
  - BPRED_WIDTH default constant.
  - Typedef bpred_entry_t {index, pred, ghr}.
  - Typedef for the counter-state localparams shared with the counter table.
- Sub-module branch_queue: circular FIFO of bpred_entry_t with push, pop, flush, full, empty and head outputs. The top level holds the GHR, index mux, update/mispredict registers and stall logic.

## Test plan
- Reset, PC=0x0000_0040 branch, i_Prediction=1 → o_Table_Index=0x010, next-cycle GHR_spec=0x001, count=1.
- Push 4 branches (depth 4), 5th branch → o_Stall=1, GHR unchanged; resolve oldest correctly → next cycle o_Table_Enable=1, o_Mispredict=0, then 5th branch accepted.
- GHR=0x0F5, predict taken, resolve not-taken → o_Mispredict=1 next cycle, o_Recover_Outcome=0, queue empty, GHR_spec={checkpoint[8:0],0}.
- Push + correct resolve on same edge with count=2 → count stays 2, update strobe carries the popped head's index and outcome.
- Resolve while empty → no o_Table_Enable, no o_Mispredict; i_Reset asserted during an update cycle → all outputs at reset values next cycle.
